// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and S-box tables (also used by KeyExpansion).
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_BYTE_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sb_state_t;

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sub_bytes_multilane_if.sv
// Valid/ready bus between AddRoundKey, the SubBytes stage and ShiftRows.
interface sub_bytes_multilane_if;
    import aes_pkg::*;

    logic [AES_STATE_W-1:0] in_data;
    logic                   in_inv;
    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] out_data;
    logic                   out_inv;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in_data, in_inv, in_valid, out_ready,
        input  in_ready, out_data, out_inv, out_valid
    );

    modport slave (
        input  in_data, in_inv, in_valid, out_ready,
        output in_ready, out_data, out_inv, out_valid
    );
endinterface

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane; the inverse table only exists when INV_EN is set.
module aes_sbox_lane
    import aes_pkg::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  logic [AES_BYTE_W-1:0] i_byte,
    input  logic                  i_inv,
    output logic [AES_BYTE_W-1:0] o_byte_c
);

    // Table lookup, mode-selected when the inverse path is built
    generate
        if (INV_EN) begin : g_inv
            assign o_byte_c = i_inv ? SBOX_INV[i_byte] : SBOX_FWD[i_byte];
        end else begin : g_fwd
            logic w_unused_inv;
            assign w_unused_inv = i_inv;
            assign o_byte_c     = SBOX_FWD[i_byte];
        end
    endgenerate

endmodule

// File: rtl/sub_bytes_multilane.sv
// Beat-serial SubBytes/InvSubBytes over a 128-bit state using LANES S-box lanes.
module sub_bytes_multilane
    import aes_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter bit          INV_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    sub_bytes_multilane_if.slave  bus
);

    localparam int unsigned NBYTES = AES_STATE_W / AES_BYTE_W;
    localparam int unsigned BEATS  = NBYTES / LANES;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned IDX_W  = $clog2(NBYTES);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_multilane: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    sb_state_t                            r_state;
    logic [CNT_W-1:0]                     r_cnt;
    logic [NBYTES-1:0][AES_BYTE_W-1:0]    r_hold;
    logic                                 r_hold_inv;
    logic [NBYTES-1:0][AES_BYTE_W-1:0]    r_out;
    logic                                 r_out_inv;
    logic                                 r_out_valid;

    logic [IDX_W-1:0]      w_idx      [LANES];
    logic [AES_BYTE_W-1:0] w_lane_in  [LANES];
    logic [AES_BYTE_W-1:0] w_lane_out [LANES];

    // Byte k*LANES+j feeds lane j; byte 0 is the most significant packed element
    generate
        for (genvar j = 0; j < int'(LANES); j++) begin : g_lane
            assign w_idx[j]     = IDX_W'((NBYTES - 1) - (32'(r_cnt) * LANES + 32'(unsigned'(j))));
            assign w_lane_in[j] = r_hold[w_idx[j]];

            aes_sbox_lane #(
                .INV_EN (INV_EN)
            ) u_lane (
                .i_byte   (w_lane_in[j]),
                .i_inv    (r_hold_inv),
                .o_byte_c (w_lane_out[j])
            );
        end
    endgenerate

    // Accept is possible when idle or when the finished result is being consumed
    assign bus.in_ready  = reset && ((r_state == S_IDLE) ||
                                     ((r_state == S_DONE) && bus.out_ready));
    assign bus.out_data  = r_out;
    assign bus.out_inv   = r_out_inv;
    assign bus.out_valid = r_out_valid;

    // Control FSM, beat counter, holding and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_hold_inv  <= 1'b0;
            r_out       <= '0;
            r_out_inv   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_hold     <= bus.in_data;
                        r_hold_inv <= INV_EN ? bus.in_inv : 1'b0;
                        r_cnt      <= '0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int j = 0; j < int'(LANES); j++) begin
                        r_out[w_idx[j]] <= w_lane_out[j];
                    end
                    r_out_inv <= r_hold_inv;
                    if (r_cnt == CNT_W'(BEATS - 1)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (bus.in_valid) begin
                            r_hold     <= bus.in_data;
                            r_hold_inv <= INV_EN ? bus.in_inv : 1'b0;
                            r_cnt      <= '0;
                            r_state    <= S_RUN;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_multilane.sv
// Directed bench for sub_bytes_multilane across lane counts and the forward-only build.
module tb_sub_bytes_multilane;
    import aes_pkg::*;

    localparam logic [127:0] FWD_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FWD_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] ALL_63  = {16{8'h63}};
    localparam logic [127:0] ALL_53  = {16{8'h53}};
    localparam logic [127:0] ALL_ED  = {16{8'hed}};
    localparam logic [127:0] ALL_FB  = {16{8'hfb}};

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sub_bytes_multilane_if b4 ();
    sub_bytes_multilane_if b1 ();
    sub_bytes_multilane_if b2 ();
    sub_bytes_multilane_if b8 ();
    sub_bytes_multilane_if b16 ();
    sub_bytes_multilane_if bn ();

    sub_bytes_multilane #(.LANES(4),  .INV_EN(1'b1)) u4  (.clk(clk), .reset(reset), .bus(b4));
    sub_bytes_multilane #(.LANES(1),  .INV_EN(1'b1)) u1  (.clk(clk), .reset(reset), .bus(b1));
    sub_bytes_multilane #(.LANES(2),  .INV_EN(1'b1)) u2  (.clk(clk), .reset(reset), .bus(b2));
    sub_bytes_multilane #(.LANES(8),  .INV_EN(1'b1)) u8  (.clk(clk), .reset(reset), .bus(b8));
    sub_bytes_multilane #(.LANES(16), .INV_EN(1'b1)) u16 (.clk(clk), .reset(reset), .bus(b16));
    sub_bytes_multilane #(.LANES(4),  .INV_EN(1'b0)) un  (.clk(clk), .reset(reset), .bus(bn));

    task automatic drive_defaults();
        b4.in_data = '0;  b4.in_inv = 1'b0;  b4.in_valid = 1'b0;  b4.out_ready = 1'b1;
        b1.in_data = '0;  b1.in_inv = 1'b0;  b1.in_valid = 1'b0;  b1.out_ready = 1'b1;
        b2.in_data = '0;  b2.in_inv = 1'b0;  b2.in_valid = 1'b0;  b2.out_ready = 1'b1;
        b8.in_data = '0;  b8.in_inv = 1'b0;  b8.in_valid = 1'b0;  b8.out_ready = 1'b1;
        b16.in_data = '0; b16.in_inv = 1'b0; b16.in_valid = 1'b0; b16.out_ready = 1'b1;
        bn.in_data = '0;  bn.in_inv = 1'b0;  bn.in_valid = 1'b0;  bn.out_ready = 1'b1;
    endtask

    // Present one state on b4 for a single cycle; returns at the negedge after the accept edge
    task automatic start_b4(input logic [127:0] d, input logic inv);
        b4.in_data  = d;
        b4.in_inv   = inv;
        b4.in_valid = 1'b1;
        @(negedge clk);
        b4.in_valid = 1'b0;
        b4.in_data  = '0;
    endtask

    // Cycles from the accept edge until b4.out_valid is seen (-1 on timeout)
    task automatic wait_b4(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (b4.out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_defaults();
        #2 reset = 1'b0;
        #1;
        checks++; if (b4.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", b4.out_valid); end
        checks++; if (b4.out_data !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", b4.out_data); end
        checks++; if (b4.out_inv !== 1'b0) begin failures++; $display("FAIL reset_out_inv got=%b exp=0", b4.out_inv); end
        checks++; if (b4.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", b4.in_ready); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (b4.in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%b exp=1", b4.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_forward();
        int lat;
        start_b4(FWD_IN, 1'b0);
        checks++; if (b4.in_ready !== 1'b0) begin failures++; $display("FAIL run_in_ready got=%b exp=0", b4.in_ready); end
        wait_b4(lat);
        checks++; if (lat != 4) begin failures++; $display("FAIL fwd_latency got=%0d exp=4", lat); end
        checks++; if (b4.out_data !== FWD_OUT) begin failures++; $display("FAIL fwd_data got=%h exp=%h", b4.out_data, FWD_OUT); end
        checks++; if (b4.out_inv !== 1'b0) begin failures++; $display("FAIL fwd_inv got=%b exp=0", b4.out_inv); end
        @(negedge clk);
        checks++; if (b4.out_valid !== 1'b0) begin failures++; $display("FAIL fwd_consumed got=%b exp=0", b4.out_valid); end
    endtask

    task automatic test_inverse();
        int lat;
        @(negedge clk);
        start_b4(FWD_OUT, 1'b1);
        wait_b4(lat);
        checks++; if (lat != 4) begin failures++; $display("FAIL inv_latency got=%0d exp=4", lat); end
        checks++; if (b4.out_data !== FWD_IN) begin failures++; $display("FAIL inv_data got=%h exp=%h", b4.out_data, FWD_IN); end
        checks++; if (b4.out_inv !== 1'b1) begin failures++; $display("FAIL inv_inv got=%b exp=1", b4.out_inv); end
        @(negedge clk);
    endtask

    task automatic test_lane_sweep();
        int l1, l2, l8, l16;
        logic [127:0] d1, d2, d8, d16;
        l1 = 0; l2 = 0; l8 = 0; l16 = 0;
        d1 = '0; d2 = '0; d8 = '0; d16 = '0;
        @(negedge clk);
        b1.in_valid = 1'b1; b2.in_valid = 1'b1; b8.in_valid = 1'b1; b16.in_valid = 1'b1;
        @(negedge clk);
        b1.in_valid = 1'b0; b2.in_valid = 1'b0; b8.in_valid = 1'b0; b16.in_valid = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (b1.out_valid === 1'b1 && l1 == 0)   begin l1 = n;  d1 = b1.out_data;  end
            if (b2.out_valid === 1'b1 && l2 == 0)   begin l2 = n;  d2 = b2.out_data;  end
            if (b8.out_valid === 1'b1 && l8 == 0)   begin l8 = n;  d8 = b8.out_data;  end
            if (b16.out_valid === 1'b1 && l16 == 0) begin l16 = n; d16 = b16.out_data; end
        end
        checks++; if (l1 != 16) begin failures++; $display("FAIL lanes1_latency got=%0d exp=16", l1); end
        checks++; if (l2 != 8)  begin failures++; $display("FAIL lanes2_latency got=%0d exp=8", l2); end
        checks++; if (l8 != 2)  begin failures++; $display("FAIL lanes8_latency got=%0d exp=2", l8); end
        checks++; if (l16 != 1) begin failures++; $display("FAIL lanes16_latency got=%0d exp=1", l16); end
        checks++; if (d1 !== ALL_63)  begin failures++; $display("FAIL lanes1_data got=%h exp=%h", d1, ALL_63); end
        checks++; if (d2 !== ALL_63)  begin failures++; $display("FAIL lanes2_data got=%h exp=%h", d2, ALL_63); end
        checks++; if (d8 !== ALL_63)  begin failures++; $display("FAIL lanes8_data got=%h exp=%h", d8, ALL_63); end
        checks++; if (d16 !== ALL_63) begin failures++; $display("FAIL lanes16_data got=%h exp=%h", d16, ALL_63); end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        b4.out_ready = 1'b0;
        start_b4(FWD_IN, 1'b0);
        wait_b4(lat);
        checks++; if (lat != 4) begin failures++; $display("FAIL bp_first_latency got=%0d exp=4", lat); end
        b4.in_data  = FWD_OUT;
        b4.in_inv   = 1'b1;
        b4.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (b4.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, b4.out_valid); end
            checks++; if (b4.out_data !== FWD_OUT) begin failures++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=%h", i, b4.out_data, FWD_OUT); end
            checks++; if (b4.in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_in_ready cyc=%0d got=%b exp=0", i, b4.in_ready); end
            @(negedge clk);
        end
        b4.out_ready = 1'b1;
        #1;
        checks++; if (b4.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", b4.in_ready); end
        @(negedge clk);
        b4.in_valid = 1'b0;
        b4.in_data  = '0;
        checks++; if (b4.out_valid !== 1'b0) begin failures++; $display("FAIL bp_consumed got=%b exp=0", b4.out_valid); end
        checks++; if (b4.in_ready !== 1'b0) begin failures++; $display("FAIL bp_b2b_run got=%b exp=0", b4.in_ready); end
        wait_b4(lat);
        checks++; if (lat != 4) begin failures++; $display("FAIL bp_b2b_latency got=%0d exp=4", lat); end
        checks++; if (b4.out_data !== FWD_IN) begin failures++; $display("FAIL bp_b2b_data got=%h exp=%h", b4.out_data, FWD_IN); end
        checks++; if (b4.out_inv !== 1'b1) begin failures++; $display("FAIL bp_b2b_inv got=%b exp=1", b4.out_inv); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat;
        @(negedge clk);
        start_b4(FWD_IN, 1'b1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (b4.out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid got=%b exp=0", b4.out_valid); end
        checks++; if (b4.out_data !== 128'h0) begin failures++; $display("FAIL abort_out_data got=%h exp=0", b4.out_data); end
        checks++; if (b4.out_inv !== 1'b0) begin failures++; $display("FAIL abort_out_inv got=%b exp=0", b4.out_inv); end
        checks++; if (b4.in_ready !== 1'b0) begin failures++; $display("FAIL abort_in_ready got=%b exp=0", b4.in_ready); end
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (b4.out_valid !== 1'b0) begin failures++; $display("FAIL abort_no_result got=%b exp=0", b4.out_valid); end
        start_b4(ALL_53, 1'b0);
        wait_b4(lat);
        checks++; if (lat != 4) begin failures++; $display("FAIL post_abort_latency got=%0d exp=4", lat); end
        checks++; if (b4.out_data !== ALL_ED) begin failures++; $display("FAIL post_abort_data got=%h exp=%h", b4.out_data, ALL_ED); end
        @(negedge clk);
    endtask

    task automatic test_inv_disabled();
        int lat;
        @(negedge clk);
        bn.in_data  = ALL_63;
        bn.in_inv   = 1'b1;
        bn.in_valid = 1'b1;
        @(negedge clk);
        bn.in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bn.out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        checks++; if (lat != 4) begin failures++; $display("FAIL fwdonly_latency got=%0d exp=4", lat); end
        checks++; if (bn.out_data !== ALL_FB) begin failures++; $display("FAIL fwdonly_data got=%h exp=%h", bn.out_data, ALL_FB); end
        checks++; if (bn.out_inv !== 1'b0) begin failures++; $display("FAIL fwdonly_inv got=%b exp=0", bn.out_inv); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_lane_sweep();
        test_backpressure();
        test_reset_abort();
        test_inv_disabled();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
